logic_gate_bank: RTL and testbench

- Registered bank of the seven basic two-input logic functions (AND, OR, NOT, NAND, NOR, XOR, XNOR), applied bitwise over WIDTH-bit operands.
- Operands are captured on a valid strobe; all results appear together one clock later.
- Used as a leaf utility and a bring-up/demo block in the datapath.

---
 rtl/logic_gate_bank_pkg.sv | 25 ++
 rtl/logic_gate_bank_gate_eval.sv | 58 +++++
 rtl/logic_gate_bank.sv | 104 ++++++++++
 tb/tb_logic_gate_bank.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_gate_bank_pkg.sv
// ============================================================================
// Module      : logic_gate_bank_pkg
// Description : Shared types and constants for the logic gate bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package logic_gate_bank_pkg;

    localparam int NUM_GATES = 7;

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_NOT    = 3'd2,
        OP_NAND   = 3'd3,
        OP_NOR    = 3'd4,
        OP_XOR    = 3'd5,
        OP_XNOR   = 3'd6,
        OP_PASS_A = 3'd7
    } gate_op_e;

endpackage

`default_nettype wire

// File: rtl/logic_gate_bank_gate_eval.sv
// ============================================================================
// Module      : gate_eval
// Description : Combinational bitwise evaluation of the seven basic gates;
//               adds an op-selected result when LOGIC_GATE_BANK_SEL_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_eval
    import logic_gate_bank_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef LOGIC_GATE_BANK_SEL_EN
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y_sel,
`endif
    output logic [WIDTH-1:0] y_and,
    output logic [WIDTH-1:0] y_or,
    output logic [WIDTH-1:0] y_not,
    output logic [WIDTH-1:0] y_nand,
    output logic [WIDTH-1:0] y_nor,
    output logic [WIDTH-1:0] y_xor,
    output logic [WIDTH-1:0] y_xnor
);

    assign y_and  = a & b;
    assign y_or   = a | b;
    assign y_not  = ~a;
    assign y_nand = ~(a & b);
    assign y_nor  = ~(a | b);
    assign y_xor  = a ^ b;
    assign y_xnor = ~(a ^ b);

`ifdef LOGIC_GATE_BANK_SEL_EN
    always_comb begin
        y_sel = a;
        case (gate_op_e'(op))
            OP_AND:    y_sel = y_and;
            OP_OR:     y_sel = y_or;
            OP_NOT:    y_sel = y_not;
            OP_NAND:   y_sel = y_nand;
            OP_NOR:    y_sel = y_nor;
            OP_XOR:    y_sel = y_xor;
            OP_XNOR:   y_sel = y_xnor;
            OP_PASS_A: y_sel = a;
            default:   y_sel = a;
        endcase
    end
`else
    // Without the selector only the fixed gate outputs exist.
`endif

endmodule

`default_nettype wire

// File: rtl/logic_gate_bank.sv
// ============================================================================
// Module      : logic_gate_bank
// Description : Registered bank of seven bitwise gates, one-cycle latency.
//               Optional op-selected output under LOGIC_GATE_BANK_SEL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_gate_bank
    import logic_gate_bank_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef LOGIC_GATE_BANK_SEL_EN
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y_sel,
`endif
    output logic             out_valid,
    output logic [WIDTH-1:0] y_and,
    output logic [WIDTH-1:0] y_or,
    output logic [WIDTH-1:0] y_not,
    output logic [WIDTH-1:0] y_nand,
    output logic [WIDTH-1:0] y_nor,
    output logic [WIDTH-1:0] y_xor,
    output logic [WIDTH-1:0] y_xnor
);

    logic [WIDTH-1:0] w_and, w_or, w_not, w_nand, w_nor, w_xor, w_xnor;
    logic [WIDTH-1:0] r_and, r_or, r_not, r_nand, r_nor, r_xor, r_xnor;
    logic             r_valid;
`ifdef LOGIC_GATE_BANK_SEL_EN
    logic [WIDTH-1:0] w_sel;
    logic [WIDTH-1:0] r_sel;
`endif

    gate_eval #(
        .WIDTH (WIDTH)
    ) u_gate_eval (
        .a      (a),
        .b      (b),
`ifdef LOGIC_GATE_BANK_SEL_EN
        .op     (op),
        .y_sel  (w_sel),
`endif
        .y_and  (w_and),
        .y_or   (w_or),
        .y_not  (w_not),
        .y_nand (w_nand),
        .y_nor  (w_nor),
        .y_xor  (w_xor),
        .y_xnor (w_xnor)
    );

    // Results load only on an accepted input, so idle-cycle X on a/b never reaches the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_and   <= '0;
            r_or    <= '0;
            r_not   <= '0;
            r_nand  <= '0;
            r_nor   <= '0;
            r_xor   <= '0;
            r_xnor  <= '0;
`ifdef LOGIC_GATE_BANK_SEL_EN
            r_sel   <= '0;
`endif
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_and  <= w_and;
                r_or   <= w_or;
                r_not  <= w_not;
                r_nand <= w_nand;
                r_nor  <= w_nor;
                r_xor  <= w_xor;
                r_xnor <= w_xnor;
`ifdef LOGIC_GATE_BANK_SEL_EN
                r_sel  <= w_sel;
`endif
            end
        end
    end

    assign out_valid = r_valid;
    assign y_and     = r_and;
    assign y_or      = r_or;
    assign y_not     = r_not;
    assign y_nand    = r_nand;
    assign y_nor     = r_nor;
    assign y_xor     = r_xor;
    assign y_xnor    = r_xnor;
`ifdef LOGIC_GATE_BANK_SEL_EN
    assign y_sel     = r_sel;
`endif

endmodule

`default_nettype wire

// File: tb/tb_logic_gate_bank.sv
// ============================================================================
// Module      : tb_logic_gate_bank
// Description : Directed self-checking bench for logic_gate_bank (WIDTH 1 and 8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_logic_gate_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       a1 = 1'b0, b1 = 1'b0;
    logic [7:0] a8 = 8'h00, b8 = 8'h00;
    logic [2:0] op = 3'd0;

    logic       v1, y1_and, y1_or, y1_not, y1_nand, y1_nor, y1_xor, y1_xnor;
    logic       v8;
    logic [7:0] y8_and, y8_or, y8_not, y8_nand, y8_nor, y8_xor, y8_xnor;
`ifdef LOGIC_GATE_BANK_SEL_EN
    logic       y1_sel;
    logic [7:0] y8_sel;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    logic_gate_bank #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a1),
        .b         (b1),
`ifdef LOGIC_GATE_BANK_SEL_EN
        .op        (op),
        .y_sel     (y1_sel),
`endif
        .out_valid (v1),
        .y_and     (y1_and),
        .y_or      (y1_or),
        .y_not     (y1_not),
        .y_nand    (y1_nand),
        .y_nor     (y1_nor),
        .y_xor     (y1_xor),
        .y_xnor    (y1_xnor)
    );

    logic_gate_bank #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a8),
        .b         (b8),
`ifdef LOGIC_GATE_BANK_SEL_EN
        .op        (op),
        .y_sel     (y8_sel),
`endif
        .out_valid (v8),
        .y_and     (y8_and),
        .y_or      (y8_or),
        .y_not     (y8_not),
        .y_nand    (y8_nand),
        .y_nor     (y8_nor),
        .y_xor     (y8_xor),
        .y_xnor    (y8_xnor)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] ea, input logic [7:0] eb);
        chk({tag, "_and"},  y8_and,  ea & eb);
        chk({tag, "_or"},   y8_or,   ea | eb);
        chk({tag, "_not"},  y8_not,  ~ea);
        chk({tag, "_nand"}, y8_nand, ~(ea & eb));
        chk({tag, "_nor"},  y8_nor,  ~(ea | eb));
        chk({tag, "_xor"},  y8_xor,  ea ^ eb);
        chk({tag, "_xnor"}, y8_xnor, ~(ea ^ eb));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_v1"},   {7'd0, v1}, 8'h00);
        chk({tag, "_v8"},   {7'd0, v8}, 8'h00);
        chk({tag, "_nand1"}, {7'd0, y1_nand}, 8'h00);
        chk({tag, "_nor1"},  {7'd0, y1_nor},  8'h00);
        chk({tag, "_xnor1"}, {7'd0, y1_xnor}, 8'h00);
        chk({tag, "_not1"},  {7'd0, y1_not},  8'h00);
        chk({tag, "_and8"},  y8_and,  8'h00);
        chk({tag, "_or8"},   y8_or,   8'h00);
        chk({tag, "_not8"},  y8_not,  8'h00);
        chk({tag, "_nand8"}, y8_nand, 8'h00);
        chk({tag, "_nor8"},  y8_nor,  8'h00);
        chk({tag, "_xor8"},  y8_xor,  8'h00);
        chk({tag, "_xnor8"}, y8_xnor, 8'h00);
`ifdef LOGIC_GATE_BANK_SEL_EN
        chk({tag, "_sel8"},  y8_sel,  8'h00);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // WIDTH=1 truth table: (a,b) = 00,01,10,11,00
    bit t_a    [5] = '{0, 0, 1, 1, 0};
    bit t_b    [5] = '{0, 1, 0, 1, 0};
    bit e_and  [5] = '{0, 0, 0, 1, 0};
    bit e_or   [5] = '{0, 1, 1, 1, 0};
    bit e_not  [5] = '{1, 1, 0, 0, 1};
    bit e_nand [5] = '{1, 1, 1, 0, 1};
    bit e_nor  [5] = '{1, 0, 0, 0, 1};
    bit e_xor  [5] = '{0, 1, 1, 0, 0};
    bit e_xnor [5] = '{1, 0, 0, 1, 1};
    logic [7:0] e_sel [8] = '{8'h42, 8'hDB, 8'h3C, 8'hBD, 8'h24, 8'h99, 8'h66, 8'hC3};

    initial begin
        logic [7:0] ra, rb;

        // Reset and release
        #3 rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_all_zero("reset");

        // Truth table on the 1-bit instance; 8-bit instance sees F0/AA throughout
        a8 = 8'hF0;
        b8 = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            a1 = t_a[i];
            b1 = t_b[i];
            in_valid = 1'b1;
            tick();
            chk($sformatf("tt%0d_v", i),    {7'd0, v1},      8'h01);
            chk($sformatf("tt%0d_and", i),  {7'd0, y1_and},  {7'd0, e_and[i]});
            chk($sformatf("tt%0d_or", i),   {7'd0, y1_or},   {7'd0, e_or[i]});
            chk($sformatf("tt%0d_not", i),  {7'd0, y1_not},  {7'd0, e_not[i]});
            chk($sformatf("tt%0d_nand", i), {7'd0, y1_nand}, {7'd0, e_nand[i]});
            chk($sformatf("tt%0d_nor", i),  {7'd0, y1_nor},  {7'd0, e_nor[i]});
            chk($sformatf("tt%0d_xor", i),  {7'd0, y1_xor},  {7'd0, e_xor[i]});
            chk($sformatf("tt%0d_xnor", i), {7'd0, y1_xnor}, {7'd0, e_xnor[i]});
        end

        // WIDTH=8 hand-computed vector
        chk("w8_and",  y8_and,  8'hA0);
        chk("w8_or",   y8_or,   8'hFA);
        chk("w8_not",  y8_not,  8'h0F);
        chk("w8_nand", y8_nand, 8'h5F);
        chk("w8_nor",  y8_nor,  8'h05);
        chk("w8_xor",  y8_xor,  8'h5A);
        chk("w8_xnor", y8_xnor, 8'hA5);

        // Hold: three idle cycles with toggling (and one X) operands
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a1 = 1'($urandom);
            b1 = 1'($urandom);
            a8 = (i == 1) ? 8'hxx : 8'($urandom);
            b8 = (i == 1) ? 8'hxx : 8'($urandom);
            tick();
            chk($sformatf("hold%0d_v8", i),    {7'd0, v8}, 8'h00);
            chk($sformatf("hold%0d_v1", i),    {7'd0, v1}, 8'h00);
            chk($sformatf("hold%0d_not1", i),  {7'd0, y1_not},  8'h01);
            chk($sformatf("hold%0d_xnor1", i), {7'd0, y1_xnor}, 8'h01);
            chk8($sformatf("hold%0d", i), 8'hF0, 8'hAA);
        end

        // Throughput: 16 back-to-back random valids
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            a8 = ra;
            b8 = rb;
            in_valid = 1'b1;
            tick();
            chk($sformatf("tp%0d_v", i), {7'd0, v8}, 8'h01);
            chk8($sformatf("tp%0d", i), ra, rb);
        end
        in_valid = 1'b0;
        tick();
        chk("tp_end_v", {7'd0, v8}, 8'h00);
        chk8("tp_end_hold", ra, rb);

        // Mid-stream asynchronous reset with outputs nonzero
        a8 = 8'hFF;
        b8 = 8'h00;
        a1 = 1'b1;
        b1 = 1'b0;
        in_valid = 1'b1;
        tick();
        chk("pre_rst_or", y8_or, 8'hFF);
        a8 = 8'h3C;
        b8 = 8'h5A;
        #3 rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        chk_all_zero("post_rst");
        a8 = 8'h3C;
        b8 = 8'h5A;
        in_valid = 1'b1;
        tick();
        chk("post_rst_v", {7'd0, v8}, 8'h01);
        chk8("post_rst", 8'h3C, 8'h5A);

`ifdef LOGIC_GATE_BANK_SEL_EN
        a8 = 8'hC3;
        b8 = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            tick();
            chk($sformatf("sel_op%0d", i), y8_sel, e_sel[i]);
        end
        in_valid = 1'b0;
        op = 3'd0;
        tick();
        chk("sel_hold", y8_sel, 8'hC3);
`endif

        in_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
